// File: rtl/ldo_ctrl_pkg.sv
// Shared types and helpers for the dual-array digital LDO controller.
package ldo_ctrl_pkg;

  // Which gate array the comparator is currently steering.
  typedef enum logic {
    COARSE = 1'b0,
    FINE   = 1'b1
  } state_t;

  localparam int L_DEFAULT = 16;
  localparam int M_DEFAULT = 16;

  // Bits needed to hold a unit count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/therm_dec.sv
// Binary count to active-low thermometer code. A count of n turns on the n
// most significant units (those bits are 0); the rest stay 1.
module therm_dec
  import ldo_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [cnt_width(W)-1:0] count,
  output logic [W-1:0]            code
);

  // Bit i is on exactly when it lies in the top `count` positions.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      code[i] = (i < (W - int'(count)));
    end
  end

endmodule

// File: rtl/ldo_dual_sr_ctrl.sv
// Coarse/fine thermometer array driver for the digital LDO power stage.
// Build option: define LDO_LOCK_FREEZE_EN to freeze both counts while the
// limit-cycle lock flag is set; otherwise lock is status only.
module ldo_dual_sr_ctrl
  import ldo_ctrl_pkg::*;
#(
  parameter int L            = L_DEFAULT,
  parameter int M            = M_DEFAULT,
  parameter int LOCK_TOGGLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    comp_in,
  input  logic                    force_coarse,
  output logic [L-1:0]            fine_out,
  output logic [M-1:0]            coarse_out,
  output logic [cnt_width(L)-1:0] fine_cnt,
  output logic [cnt_width(M)-1:0] coarse_cnt,
  output logic                    in_fine,
  output logic                    lock,
  output logic                    sat_hi,
  output logic                    sat_lo
);

  localparam int FW = cnt_width(L);
  localparam int CW = cnt_width(M);

  localparam logic [FW-1:0] L_CNT  = FW'(L);
  localparam logic [FW-1:0] L_HALF = FW'(L / 2);
  localparam logic [FW:0]   L_EXT  = (FW + 1)'(L);
  localparam logic [CW-1:0] M_CNT  = CW'(M);
  localparam logic [CW:0]   M_EXT  = (CW + 1)'(M);
  localparam logic [2:0]    LOCK_T = 3'(LOCK_TOGGLES);

  state_t        state_q, state_d;
  logic [FW-1:0] fine_q, fine_d;
  logic [CW-1:0] coarse_q, coarse_d;
  logic [2:0]    tog_q, tog_d;
  logic          prev_q, prev_d;
  logic          first_q, first_d;
  logic          lock_q, lock_d;
  logic          sat_hi_q, sat_hi_d;
  logic          sat_lo_q, sat_lo_d;

  // One bit wider than the counters so the bounds show up without wrapping.
  logic [FW:0]   fine_up, fine_dn;
  logic [CW:0]   coarse_up, coarse_dn;
  logic [2:0]    tog_inc;
  logic          flip;
  logic          carry_borrow;
  logic          freeze;

`ifdef LDO_LOCK_FREEZE_EN
  assign freeze = lock_q;
`else
  assign freeze = 1'b0;
`endif

  assign fine_up   = {1'b0, fine_q} + (FW + 1)'(1);
  assign fine_dn   = {1'b0, fine_q} - (FW + 1)'(1);
  assign coarse_up = {1'b0, coarse_q} + (CW + 1)'(1);
  assign coarse_dn = {1'b0, coarse_q} - (CW + 1)'(1);
  assign flip      = (comp_in != prev_q);
  assign tog_inc   = (tog_q == LOCK_T) ? tog_q : tog_q + 3'd1;

  // Next-state, count and flag decisions for one comparator sample.
  // NOTE: every variable gets a hold default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    fine_d       = fine_q;
    coarse_d     = coarse_q;
    tog_d        = tog_q;
    prev_d       = prev_q;
    first_d      = first_q;
    lock_d       = lock_q;
    sat_hi_d     = sat_hi_q;
    sat_lo_d     = sat_lo_q;
    carry_borrow = 1'b0;

    if (en) begin
      prev_d   = comp_in;
      sat_hi_d = (coarse_q == M_CNT) && (fine_q == L_CNT) && comp_in;
      sat_lo_d = (coarse_q == '0) && (fine_q == '0) && !comp_in;

      if (force_coarse) begin
        state_d = COARSE;
        first_d = 1'b1;
        lock_d  = 1'b0;
        tog_d   = '0;
      end else begin
        first_d = 1'b0;
        unique case (state_q)
          COARSE: begin
            tog_d  = '0;
            lock_d = 1'b0;
            if (first_q || !flip) begin
              if (comp_in) begin
                if (coarse_up <= M_EXT) coarse_d = coarse_up[CW-1:0];
              end else begin
                if (!coarse_dn[CW]) coarse_d = coarse_dn[CW-1:0];
              end
            end else begin
              // First polarity flip: park fine mid-scale and track with it.
              fine_d  = L_HALF;
              state_d = FINE;
            end
          end
          FINE: begin
            if (!freeze) begin
              if (comp_in) begin
                if (fine_up <= L_EXT) begin
                  fine_d = fine_up[FW-1:0];
                end else if (coarse_up <= M_EXT) begin
                  coarse_d     = coarse_up[CW-1:0];
                  fine_d       = L_HALF;
                  carry_borrow = 1'b1;
                end
              end else begin
                if (!fine_dn[FW]) begin
                  fine_d = fine_dn[FW-1:0];
                end else if (!coarse_dn[CW]) begin
                  coarse_d     = coarse_dn[CW-1:0];
                  fine_d       = L_HALF;
                  carry_borrow = 1'b1;
                end
              end
            end
            if (carry_borrow) begin
              lock_d = 1'b0;
              tog_d  = '0;
            end else if (flip) begin
              tog_d = tog_inc;
              if (tog_inc == LOCK_T) lock_d = 1'b1;
            end else begin
              // A cleared counter means the previous sample was also equal.
              tog_d = '0;
              if (tog_q == '0) lock_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State register with asynchronous reset to the all-off COARSE state.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COARSE;
      fine_q   <= '0;
      coarse_q <= '0;
      tog_q    <= '0;
      prev_q   <= 1'b0;
      first_q  <= 1'b1;
      lock_q   <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fine_q   <= fine_d;
      coarse_q <= coarse_d;
      tog_q    <= tog_d;
      prev_q   <= prev_d;
      first_q  <= first_d;
      lock_q   <= lock_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  therm_dec #(.W(L)) u_fine_dec (
    .count (fine_q),
    .code  (fine_out)
  );

  therm_dec #(.W(M)) u_coarse_dec (
    .count (coarse_q),
    .code  (coarse_out)
  );

  assign fine_cnt   = fine_q;
  assign coarse_cnt = coarse_q;
  assign in_fine    = (state_q == FINE);
  assign lock       = lock_q;
  assign sat_hi     = sat_hi_q;
  assign sat_lo     = sat_lo_q;

endmodule

// File: doc/ldo_dual_sr_ctrl.md
Name: ldo_dual_sr_ctrl

Overview:
Parametrised successor to the fixed 16/16 fine/coarse shift-register array driver for the digital LDO power stage. It drives two thermometer-coded PMOS gate arrays, coarse (M units) and fine (L units), from the 1-bit clocked comparator. A small FSM moves between the arrays on its own, replacing the external fine_en/coarse_en select:
- coarse tracking first;
- fine tracking after the first comparator polarity flip;
- automatic coarse carry/borrow when the fine array saturates.
It also flags lock (limit-cycle) and saturation to the analog-assist loop.

Parameters:
- L, 16, number of fine units; must be even and ≥4.
- M, 16, number of coarse units; must be ≥2.
- LOCK_TOGGLES, 4, number of consecutive alternating comparator samples in FINE that asserts lock.

Ports:
- clk  in  1  system clock; the comparator is sampled on each rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  when 0, all state and outputs hold.
- comp_in  in  1  1 = Vout below Vref (enable one more unit); 0 = Vout above Vref (disable one unit).
- force_coarse  in  1  synchronous request to return to COARSE (load-transient hook).
- fine_out  out  L  fine gate drive, active-low; bit=0 means unit on.
- coarse_out  out  M  coarse gate drive, active-low.
- fine_cnt  out  clog2(L+1)  number of fine units on, binary.
- coarse_cnt  out  clog2(M+1)  number of coarse units on, binary.
- in_fine  out  1  FSM state is FINE.
- lock  out  1  limit cycle detected.
- sat_hi  out  1  coarse_cnt==M, fine_cnt==L and comp_in==1.
- sat_lo  out  1  coarse_cnt==0, fine_cnt==0 and comp_in==0.

Behaviour:
- Reset (async):
  - fine_cnt=0, coarse_cnt=0;
  - fine_out and coarse_out all ones;
  - state COARSE;
  - lock=0, sat_hi=0, sat_lo=0;
  - prev_comp=0.
- Reset mid-operation: same values, applied immediately.
- Thermometer mapping: count n turns on bits [W-1 : W-n], i.e. those bits are 0; the remaining bits are 1. Example: n=3, W=16 gives 16'h1FFF.
- Latency: the outputs reflect comp_in sampled at edge k right after edge k. Outputs decode combinationally from registered counts, with no extra pipeline stage.
- en=0: all registers hold, including prev_comp and the lock counter.
- Priority order: rst > en=0 > force_coarse > FSM.
- force_coarse=1:
  - next state COARSE;
  - counts hold;
  - lock and the toggle counter clear.
- COARSE state:
  - If comp_in==prev_comp, or this is the first cycle after reset/force: coarse_cnt ±1, saturating at 0..M.
  - Otherwise (polarity flip): coarse_cnt holds, fine_cnt loads L/2, next state FINE.
- FINE state:
  - Normally fine_cnt ±1.
  - comp_in=1 with fine_cnt==L and coarse_cnt<M: coarse_cnt+1 and fine_cnt loads L/2 (carry).
  - comp_in=0 with fine_cnt==0 and coarse_cnt>0: coarse_cnt-1 and fine_cnt loads L/2 (borrow).
  - At the full extremes, everything holds and sat_hi/sat_lo assert for that cycle (registered).
- prev_comp updates every enabled cycle.
- Lock detection:
  - In FINE, a 3-bit toggle counter increments when comp_in!=prev_comp and otherwise clears.
  - lock sets when the counter reaches LOCK_TOGGLES; the counter saturates there.
  - lock clears on two consecutive equal samples, on any carry/borrow, or on force_coarse.
- Width rule: all count arithmetic is done at counter width + 1 to detect bounds; there is no wrap-around.

Optional Feature:
- Macro: LDO_LOCK_FREEZE_EN.
- Defined: while lock=1, fine_cnt and coarse_cnt freeze, so the power stage stops dithering. The comparator is still tracked, and the lock-clear rule above releases the freeze.
- Undefined: lock is status only and the counts keep dithering.

Decomposition:
- Shared package ldo_ctrl_pkg holds:
  - state enum {COARSE, FINE};
  - default L/M constants;
  - the count-width function clog2(n+1).
- Sub-module therm_dec (parameter W, input count, output active-low W-bit code), instantiated twice.

Test Plan:
- Reset check: pulse rst mid-run while counts are nonzero → immediately fine_out=16'hFFFF, coarse_out=16'hFFFF, in_fine=0, lock=0.
- Coarse entry to fine: comp_in=1 for 3 cycles → coarse_out=16'h1FFF. Then comp_in=0 → coarse_out holds 16'h1FFF, fine_out=16'h00FF (fine_cnt=8), in_fine=1.
- Carry: in FINE, hold comp_in=1 until fine_cnt=16, then one more cycle → coarse_cnt+1 and fine_cnt=8. Symmetric borrow with comp_in=0 from fine_cnt=0.
- Saturation: coarse_cnt=16, fine_cnt=16, comp_in=1 → counts hold and sat_hi=1. Mirror case with all counts 0 and comp_in=0 → sat_lo=1.
- Lock: in FINE, alternate comp_in 1,0,1,0 → lock=1 after the 4th toggle. With LDO_LOCK_FREEZE_EN, fine_cnt is frozen; two equal samples clear lock.
- Override and enable: force_coarse=1 while in FINE with lock=1 → in_fine=0, lock=0, counts unchanged. en=0 for 5 cycles with comp_in toggling → no output change.
